// File: rtl/mp_pkg.sv
// Shared max-pool types: data width, lane count, window and packed-group layouts.
// Also reused by the window buffer and the next ShuffleNet stage.
package mp_pkg;

    localparam int DW   = 16;
    localparam int PACK = 4;

    typedef logic signed [DW-1:0] data_t;
    typedef data_t [8:0]          window_t;
    typedef data_t [PACK-1:0]     group_t;

    function automatic data_t smax(input data_t a, input data_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_unit_max3.sv
// Combinational three-input signed maximum.
module max3
    import mp_pkg::*;
(
    input  data_t a_i,
    input  data_t b_i,
    input  data_t c_i,
    output data_t max_o
);

    assign max_o = smax(smax(a_i, b_i), c_i);

endmodule

// File: rtl/max_pool_unit.sv
// 3x3 max-pool: row-max stage, column-max stage, then a 4-lane packer
// that tracks lane and output-row position and flags frame completion.
module max_pool_unit
    import mp_pkg::*;
#(
    parameter int ROWS = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  window_t         win,
    input  logic            win_valid,
    input  logic            row_last,
    output group_t          out,
    output logic [PACK-1:0] out_mask,
    output logic            out_valid,
    output logic            frame_done
);

    localparam int LW  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;

    data_t [2:0]     rmax_d, rmax_q;
    logic            s1_valid_q, s1_last_q;
    data_t           res_d, res_q;
    logic            s2_valid_q, s2_last_q;

    group_t          out_d, out_q;
    logic [PACK-1:0] mask_d, mask_q;
    logic            valid_d, valid_q;
    logic            fdone_d, fdone_q;
    logic [LW-1:0]   lcnt_d, lcnt_q;
    logic [RCW-1:0]  rc_d, rc_q;

    // Row r of the window occupies win[8-3r : 6-3r].
    for (genvar r = 0; r < 3; r++) begin : g_row
        max3 u_row_max (
            .a_i   (win[8-3*r]),
            .b_i   (win[7-3*r]),
            .c_i   (win[6-3*r]),
            .max_o (rmax_d[r])
        );
    end

    max3 u_col_max (
        .a_i   (rmax_q[0]),
        .b_i   (rmax_q[1]),
        .c_i   (rmax_q[2]),
        .max_o (res_d)
    );

    // NOTE: data registers carry no reset; only the valid bits that qualify them do.
    always_ff @(posedge CLK) begin
        rmax_q <= rmax_d;
        res_q  <= res_d;
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= win_valid;
            s1_last_q  <= win_valid & row_last;
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_valid_q & s1_last_q;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        out_d   = out_q;
        mask_d  = mask_q;
        lcnt_d  = lcnt_q;
        rc_d    = rc_q;
        valid_d = 1'b0;
        fdone_d = 1'b0;
        if (s2_valid_q) begin
            if (lcnt_q == '0) begin
                out_d  = '0;
                mask_d = '0;
            end
            out_d[lcnt_q]  = res_q;
            mask_d[lcnt_q] = 1'b1;
            if ((lcnt_q == LW'(PACK-1)) || s2_last_q) begin
                valid_d = 1'b1;
                lcnt_d  = '0;
                if (s2_last_q) begin
                    if (rc_q == RCW'(ROWS-1)) begin
                        rc_d    = '0;
                        fdone_d = 1'b1;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
            end else begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q   <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            fdone_q <= 1'b0;
            lcnt_q  <= '0;
            rc_q    <= '0;
        end else begin
            out_q   <= out_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            fdone_q <= fdone_d;
            lcnt_q  <= lcnt_d;
            rc_q    <= rc_d;
        end
    end

    assign out        = out_q;
    assign out_mask   = mask_q;
    assign out_valid  = valid_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_max_pool_unit.sv
// Directed bench for max_pool_unit with a two-row frame; expected values are hand-computed.
module tb_max_pool_unit;
    import mp_pkg::*;

    localparam int ROWS = 2;

    logic            CLK = 1'b0;
    logic            RST;
    window_t         win;
    logic            win_valid;
    logic            row_last;
    group_t          out;
    logic [PACK-1:0] out_mask;
    logic            out_valid;
    logic            frame_done;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    max_pool_unit #(.ROWS(ROWS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .win        (win),
        .win_valid  (win_valid),
        .row_last   (row_last),
        .out        (out),
        .out_mask   (out_mask),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the call returns one full cycle later.
    task automatic cyc(input window_t w, input logic v, input logic l);
        win       = w;
        win_valid = v;
        row_last  = l;
        @(negedge CLK);
    endtask

    task automatic idle();
        cyc('0, 1'b0, 1'b0);
    endtask

    function automatic window_t mk(input data_t base, input int pos, input data_t m);
        window_t w;
        for (int k = 0; k < 9; k++) w[k] = base;
        w[pos] = m;
        return w;
    endfunction

    // A window presented during reset must be ignored.
    task automatic do_reset();
        RST = 1'b1;
        cyc(mk(data_t'(16'h0999), 4, data_t'(16'h0999)), 1'b1, 1'b1);
        idle();
        RST = 1'b0;
    endtask

    logic [63:0] t4_out  [4] = '{64'h0067_0066_0065_0064, 64'h0000_0000_0069_0068,
                                 64'h006D_006C_006B_006A, 64'h0000_0000_006F_006E};
    logic [3:0]  t4_mask [4] = '{4'b1111, 4'b0011, 4'b1111, 4'b0011};
    int          t4_emit [4] = '{5, 7, 11, 13};

    initial begin
        window_t w;
        int      e;

        RST = 1'b1; win = '0; win_valid = 1'b0; row_last = 1'b0;
        @(negedge CLK);
        do_reset();
        chk("reset_out",   out,        64'h0);
        chk("reset_mask",  out_mask,   64'h0);
        chk("reset_valid", out_valid,  64'h0);
        chk("reset_fdone", frame_done, 64'h0);

        // T1: single window 1..9 closing its row
        for (int k = 0; k < 9; k++) w[k] = data_t'(9 - k);
        cyc(w, 1'b1, 1'b1);
        chk("t1_lat1", out_valid, 64'h0);
        idle();
        chk("t1_lat2", out_valid, 64'h0);
        idle();
        chk("t1_valid", out_valid,  64'h1);
        chk("t1_out",   out,        64'h0000_0000_0000_0009);
        chk("t1_mask",  out_mask,   64'h1);
        chk("t1_fdone", frame_done, 64'h0);
        idle();
        chk("t1_pulse", out_valid, 64'h0);

        // T2: four back-to-back windows, maxima 5..8 at different positions
        do_reset();
        cyc(mk(data_t'(1), 0, data_t'(5)), 1'b1, 1'b0);
        cyc(mk(data_t'(2), 4, data_t'(6)), 1'b1, 1'b0);
        cyc(mk(data_t'(3), 8, data_t'(7)), 1'b1, 1'b0);
        cyc(mk(data_t'(-9), 6, data_t'(8)), 1'b1, 1'b0);
        chk("t2_early4", out_valid, 64'h0);
        idle();
        chk("t2_early5", out_valid, 64'h0);
        idle();
        chk("t2_valid", out_valid, 64'h1);
        chk("t2_out",   out,       64'h0008_0007_0006_0005);
        chk("t2_mask",  out_mask,  64'hF);
        idle();
        chk("t2_pulse", out_valid, 64'h0);

        // T3: signed comparisons, including most-positive vs most-negative
        do_reset();
        cyc(mk(data_t'(-3), 2, data_t'(-1)), 1'b1, 1'b0);
        w = '0; w[8] = data_t'(16'h7FFF); w[7] = data_t'(16'h8000);
        cyc(w, 1'b1, 1'b0);
        cyc(mk(data_t'(16'h8000), 0, data_t'(16'h8000)), 1'b1, 1'b1);
        idle();
        idle();
        chk("t3_valid", out_valid, 64'h1);
        chk("t3_out",   out,       64'h0000_8000_7FFF_FFFF);
        chk("t3_mask",  out_mask,  64'h7);

        // T4: two rows of six windows; frame ends on the fourth emission
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (i < 12) cyc(mk(data_t'(-5), i % 9, data_t'(100 + i)), 1'b1, (i == 5) || (i == 11));
            else        idle();
            e = -1;
            for (int j = 0; j < 4; j++) if (t4_emit[j] == i) e = j;
            chk($sformatf("t4_valid_c%0d", i), out_valid,  (e >= 0) ? 64'h1 : 64'h0);
            chk($sformatf("t4_fdone_c%0d", i), frame_done, (i == 13) ? 64'h1 : 64'h0);
            if (e >= 0) begin
                chk($sformatf("t4_out_e%0d", e),  out,      t4_out[e]);
                chk($sformatf("t4_mask_e%0d", e), out_mask, 64'(t4_mask[e]));
            end
        end

        // T5: partial group discarded by a mid-stream reset
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(mk(data_t'(0), i, data_t'(i + 1)), 1'b1, 1'b0);
            chk($sformatf("t5_pre_c%0d", i), out_valid, 64'h0);
        end
        RST = 1'b1;
        cyc(mk(data_t'(16'h0999), 3, data_t'(16'h0999)), 1'b1, 1'b1);
        RST = 1'b0;
        chk("t5_rst_out",   out,       64'h0);
        chk("t5_rst_valid", out_valid, 64'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(mk(data_t'(0), 8 - i, data_t'(16'h11 + i)), 1'b1, 1'b0);
            chk($sformatf("t5_post_c%0d", i), out_valid, 64'h0);
        end
        idle();
        chk("t5_early", out_valid, 64'h0);
        idle();
        chk("t5_valid", out_valid, 64'h1);
        chk("t5_out",   out,       64'h0014_0013_0012_0011);
        chk("t5_mask",  out_mask,  64'hF);

        // T6: bubbles 1,0,1,1,0,0,1 — invalid cycles carry junk data
        do_reset();
        cyc(mk(data_t'(0), 1, data_t'(16'h21)), 1'b1, 1'b0);
        cyc(mk(data_t'(0), 1, data_t'(16'h7777)), 1'b0, 1'b1);
        cyc(mk(data_t'(0), 5, data_t'(16'h22)), 1'b1, 1'b0);
        cyc(mk(data_t'(0), 7, data_t'(16'h23)), 1'b1, 1'b0);
        chk("t6_gap_a", out_valid, 64'h0);
        cyc(mk(data_t'(0), 1, data_t'(16'h7777)), 1'b0, 1'b0);
        cyc(mk(data_t'(0), 2, data_t'(16'h7777)), 1'b0, 1'b1);
        chk("t6_gap_b", out_valid, 64'h0);
        cyc(mk(data_t'(0), 3, data_t'(16'h24)), 1'b1, 1'b0);
        idle();
        chk("t6_early", out_valid, 64'h0);
        idle();
        chk("t6_valid", out_valid, 64'h1);
        chk("t6_out",   out,       64'h0024_0023_0022_0021);
        chk("t6_mask",  out_mask,  64'hF);

        // T7: row_last on a full group, then back-to-back single-window rows
        do_reset();
        cyc(mk(data_t'(0), 0, data_t'(16'h31)), 1'b1, 1'b0);
        cyc(mk(data_t'(0), 0, data_t'(16'h32)), 1'b1, 1'b0);
        cyc(mk(data_t'(0), 0, data_t'(16'h33)), 1'b1, 1'b0);
        cyc(mk(data_t'(0), 0, data_t'(16'h34)), 1'b1, 1'b1);
        cyc(mk(data_t'(0), 0, data_t'(16'h35)), 1'b1, 1'b1);
        chk("t7_early", out_valid, 64'h0);
        cyc(mk(data_t'(0), 0, data_t'(16'h36)), 1'b1, 1'b1);
        chk("t7_g0_valid", out_valid,  64'h1);
        chk("t7_g0_out",   out,        64'h0034_0033_0032_0031);
        chk("t7_g0_mask",  out_mask,   64'hF);
        chk("t7_g0_fdone", frame_done, 64'h0);
        idle();
        chk("t7_g1_valid", out_valid,  64'h1);
        chk("t7_g1_out",   out,        64'h0000_0000_0000_0035);
        chk("t7_g1_mask",  out_mask,   64'h1);
        chk("t7_g1_fdone", frame_done, 64'h1);
        idle();
        chk("t7_g2_valid", out_valid,  64'h1);
        chk("t7_g2_out",   out,        64'h0000_0000_0000_0036);
        chk("t7_g2_fdone", frame_done, 64'h0);
        idle();
        chk("t7_tail_valid", out_valid,  64'h0);
        chk("t7_tail_fdone", frame_done, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
